// File: rtl/adder_pkg.sv
// Shared width, result type and saturation limits for the adder stream stage.
package adder_pkg;

  localparam int unsigned ADDER_W = 32;

  typedef struct packed {
    logic [ADDER_W-1:0] sum;
    logic               cout;
    logic               ovf;
  } add_result_t;

  // Limits are returned 64 bits wide; callers cast down to their own width.
  function automatic logic [63:0] sat_max(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/adder_core.sv
// Combinational N-bit ripple-carry adder built from per-bit full-adder cells.
module adder_core
  import adder_pkg::*;
#(
  parameter int unsigned N = ADDER_W
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  logic carry;

  // Carry held in a loop variable so the chain is not one self-feeding vector.
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < int'(N); i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

  // Signed overflow ignores Cin, matching the original core.
  assign ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/adder_stream_stage.sv
// Two-stage valid/ready pipeline around adder_core with a sticky overflow flag.
// Optional ADDER_STREAM_SAT_EN saturates Sum whenever Overflow is set.
module adder_stream_stage
  import adder_pkg::*;
#(
  parameter int unsigned N = ADDER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Overflow,
  output logic         ovf_sticky,
  input  logic         ovf_clr
);

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } stage_res_t;

  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] a_q, b_q;
  logic         cin_q;
  logic         out_valid_q, out_valid_d;
  stage_res_t   res_q, res_d, core_res;
  logic         sticky_q, sticky_d;
  logic         s2_load, in_fire;

  adder_core #(
    .N(N)
  ) u_core (
    .a   (a_q),
    .b   (b_q),
    .cin (cin_q),
    .sum (core_res.sum),
    .cout(core_res.cout),
    .ovf (core_res.ovf)
  );

`ifdef ADDER_STREAM_SAT_EN
  localparam logic [N-1:0] SatMax = N'(sat_max(N));
  localparam logic [N-1:0] SatMin = N'(sat_min(N));

  always_comb begin
    res_d = core_res;
    if (core_res.ovf) begin
      res_d.sum = a_q[N-1] ? SatMin : SatMax;
    end
  end
`else
  assign res_d = core_res;
`endif

  // in_ready depends combinationally on out_ready so a full pipe still streams.
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    sticky_d    = sticky_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Set takes priority over a coincident clear.
    if (s2_load && core_res.ovf) begin
      sticky_d = 1'b1;
    end else if (ovf_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
      if (in_fire) begin
        a_q   <= A;
        b_q   <= B;
        cin_q <= Cin;
      end
      if (s2_load) begin
        res_q <= res_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign Sum        = res_q.sum;
  assign Cout       = res_q.cout;
  assign Overflow   = res_q.ovf;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_adder_stream_stage.sv
// Self-checking bench for adder_stream_stage (N=8) against an integer-arithmetic model.
module tb_adder_stream_stage;

  localparam int unsigned N = 8;
  localparam logic [N-1:0] MaxPos = 8'h7F;
  localparam logic [N-1:0] MinNeg = 8'h80;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] Sum;
  logic         Cout;
  logic         Overflow;
  logic         ovf_sticky;
  logic         ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [N+1:0] exp_q[$];  // {sum, cout, ovf}

  always #5 clk = ~clk;

  adder_stream_stage #(
    .N(N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Overflow  (Overflow),
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr)
  );

  // Reference: unsigned sum gives Sum/Cout, true signed range check gives Overflow.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c);
    int us, ss;
    logic [N-1:0] s;
    logic co, ov;
    us = int'(a) + int'(b) + int'(c);
    s  = us[N-1:0];
    co = (us >= 256);
    ss = int'($signed(a)) + int'($signed(b)) + int'(c);
    ov = (ss > 127) || (ss < -128);
`ifdef ADDER_STREAM_SAT_EN
    if (ov) s = a[N-1] ? MinNeg : MaxPos;
`endif
    return {s, co, ov};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (Sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h want 00", Sum); end
    n_cmp++; if ({Cout, Overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {Cout, Overflow}); end
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky: got %b want 0", ovf_sticky); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [N-1:0] va[8];
    logic [N-1:0] vb[8];
    logic         vc[8];
    logic [N+1:0] e;
    logic         sticky_m;
    va[0] = 8'h05; vb[0] = 8'h03; vc[0] = 1'b1;
    va[1] = 8'h7F; vb[1] = 8'h01; vc[1] = 1'b0;
    va[2] = 8'hFF; vb[2] = 8'h01; vc[2] = 1'b0;
    va[3] = 8'h80; vb[3] = 8'hFF; vc[3] = 1'b0;
    va[4] = 8'h7F; vb[4] = 8'h00; vc[4] = 1'b1;
    for (int i = 5; i < 8; i++) begin
      va[i] = N'($urandom); vb[i] = N'($urandom); vc[i] = 1'($urandom);
    end
    sticky_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; A = va[i]; B = vb[i]; Cin = vc[i]; out_ready = 1'b1;
      e = model(va[i], vb[i], vc[i]);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency[%0d]: got %b want 0", i, out_valid); end
      tick();
      sticky_m = sticky_m | e[0];
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if ({Sum, Cout, Overflow} !== e) begin n_err++; $display("FAIL basic_result[%0d] A=%h B=%h Cin=%b: got sum=%h c=%b v=%b want sum=%h c=%b v=%b", i, va[i], vb[i], vc[i], Sum, Cout, Overflow, e[N+1:2], e[1], e[0]); end
      n_cmp++; if (ovf_sticky !== sticky_m) begin n_err++; $display("FAIL basic_sticky[%0d]: got %b want %b", i, ovf_sticky, sticky_m); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain[%0d]: got %b want 0", i, out_valid); end
      if (sticky_m) begin
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        sticky_m = 1'b0;
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL basic_clr[%0d]: got %b want 0", i, ovf_sticky); end
      end
    end
  endtask

  task automatic test_back_pressure;
    logic [N-1:0] oa[4];
    logic [N-1:0] ob[4];
    logic         oc[4];
    int idx = 0;
    int got = 0;
    logic hold = 1'b0;
    logic [N+1:0] held;
    for (int i = 0; i < 4; i++) begin
      oa[i] = N'($urandom); ob[i] = N'($urandom); oc[i] = 1'($urandom);
    end
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin A = oa[idx]; B = ob[idx]; Cin = oc[idx]; end
      out_ready = (cyc >= 5);
      @(negedge clk);
      if (hold) begin
        n_cmp++; if (out_valid !== 1'b1 || {Sum, Cout, Overflow} !== held) begin n_err++; $display("FAIL bp_hold cyc%0d: got v=%b %h want v=1 %h", cyc, out_valid, {Sum, Cout, Overflow}, held); end
      end
      if (idx == 2 && !out_ready) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready); end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, Cin));
        idx++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bp_extra cyc%0d: got %h want nothing", cyc, {Sum, Cout, Overflow});
        end else begin
          if ({Sum, Cout, Overflow} !== exp_q[0]) begin n_err++; $display("FAIL bp_result %0d: got %h want %h", got, {Sum, Cout, Overflow}, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      hold = out_valid && !out_ready;
      held = {Sum, Cout, Overflow};
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", got); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_dup: got out_valid=%b want 0", out_valid); end
    exp_q.delete();
  endtask

  task automatic test_throughput;
    int idx = 0;
    int got = 0;
    int first = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      in_valid = (idx < 16);
      A = N'($urandom); B = N'($urandom); Cin = 1'($urandom);
      @(negedge clk);
      if (idx < 16) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL tp_in_ready cyc%0d: got %b want 1", cyc, in_ready); end
      end
      if (got > 0) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL tp_gap cyc%0d: got %b want 1", cyc, out_valid); end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, Cin));
        idx++;
      end
      if (out_valid) begin
        if (first < 0) first = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL tp_extra cyc%0d: got %h want nothing", cyc, {Sum, Cout, Overflow});
        end else begin
          if ({Sum, Cout, Overflow} !== exp_q[0]) begin n_err++; $display("FAIL tp_result %0d: got %h want %h", got, {Sum, Cout, Overflow}, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 16) begin n_err++; $display("FAIL tp_count: got %0d want 16", got); end
    n_cmp++; if (first != 2) begin n_err++; $display("FAIL tp_first_cycle: got %0d want 2", first); end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    in_valid = 1'b1; A = 8'h7F; B = 8'h01; Cin = 1'b0;
    tick();
    A = N'($urandom); B = N'($urandom);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({out_valid, in_ready, ovf_sticky} !== 3'b101) begin n_err++; $display("FAIL rst_full: got v/rdy/st=%b want 101", {out_valid, in_ready, ovf_sticky}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
    n_cmp++; if ({Sum, Cout, Overflow} !== '0) begin n_err++; $display("FAIL rst_async_data: got %h want 0", {Sum, Cout, Overflow}); end
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL rst_async_sticky: got %b want 0", ovf_sticky); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_ghost[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_sticky_set_clr;
    in_valid = 1'b1; A = 8'h7F; B = 8'h01; Cin = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    tick();
    in_valid = 1'b0;
    ovf_clr = 1'b1;
    tick();
    n_cmp++; if ({out_valid, Overflow, ovf_sticky} !== 3'b111) begin n_err++; $display("FAIL sticky_set_wins: got v/ovf/st=%b want 111", {out_valid, Overflow, ovf_sticky}); end
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_clr: got %b want 0", ovf_sticky); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_throughput();
    test_reset_midstream();
    test_sticky_set_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_stream_stage.md
Name: adder_stream_stage

Overview:
- Two-stage registered pipeline around the signed N-bit ripple adder datapath.
- Stage 1 captures operands A, B and Cin from an upstream valid/ready producer.
- Stage 2 captures Sum, Cout and Overflow and presents them to a downstream valid/ready consumer.
- Provides full-throughput, back-pressure-safe streaming of add results, plus a sticky overflow flag for software.

Parameters:
- N, 32, operand and sum width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  stage can accept operands this cycle.
- A  input  N  signed operand A.
- B  input  N  signed operand B.
- Cin  input  1  carry in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- Sum  output  N  registered signed sum.
- Cout  output  1  registered carry out of bit N-1.
- Overflow  output  1  registered signed overflow.
- ovf_sticky  output  1  set by any accepted result with Overflow=1.
- ovf_clr  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset: clk and rst_n; reset is asynchronous, active-low. While rst_n=0, all of the following are 0:
  - s1_valid, out_valid, Sum, Cout, Overflow, ovf_sticky and the operand registers.
- Reset mid-operation discards in-flight data. No partial result is emitted after reset release.
- Handshake:
  - Transfer occurs on a rising clk edge where valid && ready.
  - out_valid, once high, stays high with Sum/Cout/Overflow stable until out_ready=1.
  - in_valid may drop without a transfer.
- Stage advance rules:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load. This is a combinational path from out_ready, and it is permitted.
  - Stage 1 loads on in_valid && in_ready.
  - s1_valid clears when s2_load occurs without a new in-transfer.
- Simultaneous input and output transfers in the same cycle are legal. They sustain 1 result per cycle.
- Latency: an operand accepted at edge k gives out_valid=1 after edge k+1 (2-register latency) when unstalled.
- Arithmetic:
  - {Cout,Sum} = A + B + Cin, unsigned N+1-bit view.
  - Overflow = (A[N-1]==B[N-1]) && (Sum[N-1]!=A[N-1]). Cin is not considered, matching the core.
- ovf_sticky:
  - Set on the edge where a result with Overflow=1 loads into stage 2.
  - ovf_clr clears it. If set and clear coincide, set wins.
- Stall with a full pipeline (s1_valid && out_valid && !out_ready) forces in_ready=0. Both registers hold.
- No FSM beyond the two valid bits. States are empty, s1 only, s2 only, and full.

Optional Feature:
- Macro: ADDER_STREAM_SAT_EN.
- Defined: when Overflow=1, stage 2 stores a saturated Sum. A[N-1]=0 gives 0111..1 and A[N-1]=1 gives 1000..0. Cout and Overflow are stored unchanged.
- Undefined: Sum is the wrapped ripple result. No saturation logic is present.

Decomposition:
- Package adder_pkg holds:
  - default width constant ADDER_W=32;
  - typedef add_result_t {sum[N-1:0], cout, ovf};
  - saturation constants SAT_MAX / SAT_MIN as functions of N.
- One sub-module, adder_core: combinational N-bit add of A, B and Cin producing sum, cout and ovf, built from the existing full-adder cells. The stage instantiates it between the two registers.

Test Plan (N=8 unless noted):
- Basic add: A=0x05, B=0x03, Cin=1, out_ready=1 -> two edges later out_valid=1, Sum=0x09, Cout=0, Overflow=0.
- Signed overflow: A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Overflow=1, ovf_sticky=1. With ADDER_STREAM_SAT_EN -> Sum=0x7F.
- Carry without overflow: A=0xFF, B=0x01 -> Sum=0x00, Cout=1, Overflow=0. Negative overflow A=0x80, B=0xFF -> Sum=0x7F, Overflow=1 (SAT: 0x80).
- Back-pressure: stream 4 operand pairs with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts and out_valid with Sum holds stable. Release gives 4 results in order, none lost or duplicated.
- Full throughput: in_valid=1 and out_ready=1 for 16 cycles with random operands -> 16 results on consecutive cycles, matching the model.
- Reset mid-stream: assert rst_n=0 asynchronously with both stages full -> outputs 0 immediately. After release, out_valid stays 0 until new input. ovf_clr and set on the same edge -> ovf_sticky=1.
